// File: rtl/sr_flag_scheduler.sv
// Round-robin serialiser of set/clear commands onto a shared bank of SR flag bits.
// Opposing commands to one flag are applied one per cycle in grant order, never together.
module sr_flag_scheduler #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   localparam int IW   = $clog2(NFLAG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [NREQ*IW-1:0]   idx,
   input  logic                 flush,
   output logic [NREQ-1:0]      gnt,
   output logic [NFLAG-1:0]     flags,
   output logic                 busy,
   output logic                 conflict,
   output logic [7:0]           conflict_cnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW:0] NFLAG_W = (IW+1)'(NFLAG);

   logic [PW-1:0]    ptr_r;
   logic [NREQ-1:0]  gnt_r;
   logic [NFLAG-1:0] flags_r;
   logic             busy_r;
   logic             conflict_r;
   logic [7:0]       cnt_r;

   logic             win_valid_s;
   logic [PW-1:0]    win_s;
   logic [NREQ-1:0]  win_onehot_s;
   logic [IW-1:0]    win_idx_s;
   logic             win_op_s;
   logic [PW-1:0]    next_ptr_s;
   logic [NFLAG-1:0] flags_next_s;
   logic             conflict_s;

   // Indices at or above NFLAG address no flag; such commands are granted but dropped.
   function automatic logic in_range(input logic [IW-1:0] x);
      return ({1'b0, x} < NFLAG_W);
   endfunction

   // Round-robin winner search starting at the pointer, wrapping modulo NREQ.
   always_comb begin
      int c;
      c           = 0;
      win_valid_s = 1'b0;
      win_s       = ptr_r;
      for (int k = 0; k < NREQ; k++) begin
         c           = (int'(ptr_r) + k) % NREQ;
         win_s       = (req[c] && !win_valid_s) ? PW'(c) : win_s;
         win_valid_s = win_valid_s | req[c];
      end
   end

   // Winner decode: one-hot grant, its command, and the pointer that follows it.
   always_comb begin
      win_onehot_s = win_valid_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_s) : {NREQ{1'b0}};
      win_idx_s    = idx[int'(win_s)*IW +: IW];
      win_op_s     = op[win_s];
      next_ptr_s   = (int'(win_s) == NREQ-1) ? {PW{1'b0}} : (win_s + PW'(1));
   end

   // Next flag bank: only the winner's in-range flag moves, everything else holds.
   always_comb begin
      flags_next_s = flags_r;
      for (int f = 0; f < NFLAG; f++) begin
         flags_next_s[f] = (win_valid_s && in_range(win_idx_s) && (IW'(f) == win_idx_s))
                           ? win_op_s : flags_r[f];
      end
   end

   // Any pair of live requesters naming the same in-range flag with opposite ops.
   always_comb begin
      conflict_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = i + 1; j < NREQ; j++) begin
            conflict_s = conflict_s
                       | (req[i] & req[j] & (op[i] != op[j])
                          & (idx[i*IW +: IW] == idx[j*IW +: IW])
                          & in_range(idx[i*IW +: IW]));
         end
      end
   end

   // Grant, flag bank and pointer; flush clears the bank and freezes arbitration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r   <= {PW{1'b0}};
         gnt_r   <= {NREQ{1'b0}};
         flags_r <= {NFLAG{1'b0}};
      end else if (flush) begin
         ptr_r   <= ptr_r;
         gnt_r   <= {NREQ{1'b0}};
         flags_r <= {NFLAG{1'b0}};
      end else if (win_valid_s) begin
         ptr_r   <= next_ptr_s;
         gnt_r   <= win_onehot_s;
         flags_r <= flags_next_s;
      end else begin
         ptr_r   <= ptr_r;
         gnt_r   <= {NREQ{1'b0}};
         flags_r <= flags_r;
      end
   end

   // Activity and conflict status; the conflict counter sticks at its maximum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r     <= 1'b0;
         conflict_r <= 1'b0;
         cnt_r      <= 8'h00;
      end else begin
         busy_r     <= |req;
         conflict_r <= conflict_s;
         if (conflict_s && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'h01;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign gnt          = gnt_r;
   assign flags        = flags_r;
   assign busy         = busy_r;
   assign conflict     = conflict_r;
   assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Directed bench for sr_flag_scheduler: a cycle table for the main flow plus
// hand sequences for async reset, counter saturation and out-of-range indices.
module tb_sr_flag_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req, op;
   logic [11:0] idx;
   logic        flush;
   logic [3:0]  gnt;
   logic [7:0]  flags;
   logic        busy, conflict;
   logic [7:0]  conflict_cnt;

   logic [3:0]  req_b, op_b;
   logic [11:0] idx_b;
   logic        flush_b;
   logic [3:0]  gnt_b;
   logic [5:0]  flags_b;
   logic        busy_b, conflict_b;
   logic [7:0]  cnt_b;

   sr_flag_scheduler #(.NREQ(4), .NFLAG(8)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .flush(flush),
      .gnt(gnt), .flags(flags), .busy(busy), .conflict(conflict),
      .conflict_cnt(conflict_cnt)
   );

   sr_flag_scheduler #(.NREQ(4), .NFLAG(6)) dut6 (
      .clk(clk), .rst(rst), .req(req_b), .op(op_b), .idx(idx_b), .flush(flush_b),
      .gnt(gnt_b), .flags(flags_b), .busy(busy_b), .conflict(conflict_b),
      .conflict_cnt(cnt_b)
   );

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  op;
      logic [11:0] idx;
      logic        flush;
      logic [3:0]  gnt;
      logic [7:0]  flags;
      logic        busy;
      logic        conflict;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t v;
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
      return {3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   task automatic add(input logic [3:0] r, input logic [3:0] o, input logic [11:0] x,
                      input logic f, input logic [3:0] g, input logic [7:0] fl,
                      input logic b, input logic c, input logic [7:0] n);
      vec_t t;
      t.req = r; t.op = o; t.idx = x; t.flush = f;
      t.gnt = g; t.flags = fl; t.busy = b; t.conflict = c; t.cnt = n;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [7:0] fl,
                          input logic b, input logic c, input logic [7:0] n);
      chk({tag, " gnt"},      32'(gnt),          32'(g));
      chk({tag, " flags"},    32'(flags),        32'(fl));
      chk({tag, " busy"},     32'(busy),         32'(b));
      chk({tag, " conflict"}, 32'(conflict),     32'(c));
      chk({tag, " cnt"},      32'(conflict_cnt), 32'(n));
   endtask

   initial begin
      rst = 1'b0; req = 4'b0000; op = 4'b0000; idx = 12'h000; flush = 1'b0;
      req_b = 4'b0000; op_b = 4'b0000; idx_b = 12'h000; flush_b = 1'b0;

      //       req      op       idx            fl    gnt      flags  busy  conf  cnt
      add(4'b0100, 4'b0100, pk(0,0,5,0), 1'b0, 4'b0100, 8'h20, 1'b1, 1'b0, 8'd0);
      add(4'b0000, 4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 8'h20, 1'b0, 1'b0, 8'd0);
      add(4'b1000, 4'b1000, pk(0,0,0,6), 1'b0, 4'b1000, 8'h60, 1'b1, 1'b0, 8'd0);
      add(4'b1111, 4'b1111, pk(0,1,2,3), 1'b0, 4'b0001, 8'h61, 1'b1, 1'b0, 8'd0);
      add(4'b1111, 4'b1111, pk(0,1,2,3), 1'b0, 4'b0010, 8'h63, 1'b1, 1'b0, 8'd0);
      add(4'b1111, 4'b1111, pk(0,1,2,3), 1'b0, 4'b0100, 8'h67, 1'b1, 1'b0, 8'd0);
      add(4'b1111, 4'b1111, pk(0,1,2,3), 1'b0, 4'b1000, 8'h6F, 1'b1, 1'b0, 8'd0);
      add(4'b0000, 4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 8'h6F, 1'b0, 1'b0, 8'd0);
      add(4'b0011, 4'b0001, pk(4,4,0,0), 1'b0, 4'b0001, 8'h7F, 1'b1, 1'b1, 8'd1);
      add(4'b0010, 4'b0000, pk(0,4,0,0), 1'b0, 4'b0010, 8'h6F, 1'b1, 1'b0, 8'd1);
      add(4'b0000, 4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 8'h6F, 1'b0, 1'b0, 8'd1);
      add(4'b0011, 4'b0011, pk(4,7,0,0), 1'b0, 4'b0001, 8'h7F, 1'b1, 1'b0, 8'd1);
      add(4'b0010, 4'b0010, pk(0,7,0,0), 1'b0, 4'b0010, 8'hFF, 1'b1, 1'b0, 8'd1);
      add(4'b0010, 4'b0010, pk(0,2,0,0), 1'b1, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd1);
      add(4'b0010, 4'b0010, pk(0,2,0,0), 1'b0, 4'b0010, 8'h04, 1'b1, 1'b0, 8'd1);
      add(4'b0000, 4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 8'h04, 1'b0, 1'b0, 8'd1);
      add(4'b0011, 4'b0010, pk(6,6,0,0), 1'b1, 4'b0000, 8'h00, 1'b1, 1'b1, 8'd2);
      add(4'b0011, 4'b0010, pk(6,6,0,0), 1'b0, 4'b0001, 8'h00, 1'b1, 1'b1, 8'd3);
      add(4'b0010, 4'b0010, pk(0,6,0,0), 1'b0, 4'b0010, 8'h40, 1'b1, 1'b0, 8'd3);
      add(4'b0000, 4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 8'h40, 1'b0, 1'b0, 8'd3);

      // Reset state, held across clock edges
      repeat (2) @(posedge clk);
      #1 chk_all("reset", 4'b0000, 8'h00, 1'b0, 1'b0, 8'd0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         req = v.req; op = v.op; idx = v.idx; flush = v.flush;
         @(posedge clk);
         #1 chk_all($sformatf("v%0d", i), v.gnt, v.flags, v.busy, v.conflict, v.cnt);
      end

      // Build flags=A5, then assert reset between edges with requests held
      @(negedge clk) req = 4'b0000; flush = 1'b1;
      @(negedge clk) flush = 1'b0; req = 4'b0001; op = 4'b0001;
      foreach (tbl[k]) begin
         if (k < 4) begin
            idx = pk((k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 5 : 7, 0, 0, 0);
            @(posedge clk);
            @(negedge clk);
         end
      end
      chk_all("pre_rst", 4'b0001, 8'hA5, 1'b1, 1'b0, 8'd3);
      req = 4'b1010; op = 4'b1010; idx = pk(0,3,0,1);
      #2 rst = 1'b0;
      #1 chk_all("async_rst", 4'b0000, 8'h00, 1'b0, 1'b0, 8'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 chk_all("post_rst", 4'b0010, 8'h08, 1'b1, 1'b0, 8'd0);

      // Held opposing pair drives the conflict counter into saturation
      @(negedge clk) req = 4'b0011; op = 4'b0001; idx = pk(1,1,0,0);
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         #1;
         if (c == 1)   chk("sat c1",   32'(conflict_cnt), 32'd1);
         if (c == 254) chk("sat c254", 32'(conflict_cnt), 32'd254);
         if (c == 300) begin
            chk("sat c300",      32'(conflict_cnt), 32'd255);
            chk("sat conflict",  32'(conflict),     32'd1);
         end
      end
      @(negedge clk) req = 4'b0000;
      @(posedge clk);
      #1 chk("sat idle conflict", 32'(conflict),     32'd0);
      chk("sat idle cnt",         32'(conflict_cnt), 32'd255);

      // NFLAG=6 instance: indices 6 and 7 are granted but change nothing
      @(negedge clk) req_b = 4'b0001; op_b = 4'b0001; idx_b = pk(2,0,0,0);
      @(posedge clk);
      #1 chk("n6 set2 gnt", 32'(gnt_b), 32'h1);
      chk("n6 set2 flags", 32'(flags_b), 32'h04);
      @(negedge clk) idx_b = pk(7,0,0,0);
      @(posedge clk);
      #1 chk("n6 idx7 gnt", 32'(gnt_b), 32'h1);
      chk("n6 idx7 flags", 32'(flags_b), 32'h04);
      @(negedge clk) idx_b = pk(6,0,0,0);
      @(posedge clk);
      #1 chk("n6 idx6 gnt", 32'(gnt_b), 32'h1);
      chk("n6 idx6 flags", 32'(flags_b), 32'h04);
      @(negedge clk) req_b = 4'b0011; op_b = 4'b0001; idx_b = pk(7,7,0,0);
      @(posedge clk);
      #1 chk("n6 oor gnt", 32'(gnt_b), 32'h2);
      chk("n6 oor conflict", 32'(conflict_b), 32'h0);
      chk("n6 oor flags", 32'(flags_b), 32'h04);
      @(negedge clk) idx_b = pk(5,5,0,0);
      @(posedge clk);
      #1 chk("n6 in gnt", 32'(gnt_b), 32'h1);
      chk("n6 in flags", 32'(flags_b), 32'h24);
      chk("n6 in conflict", 32'(conflict_b), 32'h1);
      chk("n6 in cnt", 32'(cnt_b), 32'h1);
      @(negedge clk) req_b = 4'b0000;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
